// File: rtl/interval_timer_scheduler_pkg.sv
// Shared constants, FSM encoding and delay helper for the interval timer scheduler.
package interval_timer_pkg;

    localparam logic [2:0] TMR_ADDR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_ADDR_PERIOD_H = 3'd3;

    localparam logic [15:0] TMR_CTRL_ITO   = 16'h0001;
    localparam logic [15:0] TMR_CTRL_CONT  = 16'h0002;
    localparam logic [15:0] TMR_CTRL_START = 16'h0004;
    localparam logic [15:0] TMR_CTRL_STOP  = 16'h0008;

    localparam logic [31:0] TMR_MIN_DELAY = 32'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_CLR0,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_CLR1,
        ST_DONE
    } state_t;

    // The timer counts period..0, so a delay of D cycles needs period D-1; a
    // zero period never produces a timeout, hence the clamp.
    function automatic logic [31:0] period_for(input logic [31:0] delay);
        return ((delay < TMR_MIN_DELAY) ? TMR_MIN_DELAY : delay) - 32'd1;
    endfunction

endpackage

// File: rtl/interval_timer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 (mod NUM_REQ) for the first request.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last,
    output logic [2:0]         grant_idx,
    output logic               grant_valid
);

    localparam logic [NUM_REQ-1:0] LSB_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (!grant_valid && |(req & (LSB_ONE << idx))) begin
                grant_valid = 1'b1;
                grant_idx   = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/interval_timer_scheduler.sv
// Shares one Avalon-MM interval timer among NUM_REQ one-shot delay requesters,
// arbitrating round-robin and pulsing done to the served requester.
module interval_timer_scheduler
    import interval_timer_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DELAY_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [2:0]                 active_id,
    output logic [2:0]                 tmr_address,
    output logic                       tmr_chipselect,
    output logic                       tmr_write_n,
    output logic [15:0]                tmr_writedata,
    input  logic                       tmr_irq
);

    localparam logic [NUM_REQ-1:0] LSB_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             next_state;
    logic [2:0]         last;
    logic [DELAY_W-1:0] period;
    logic [DELAY_W-1:0] grant_delay;
    logic [2:0]         grant_idx;
    logic               grant_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req),
        .last       (last),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign grant_delay = DELAY_W'(req_delay >> (DELAY_W * int'(grant_idx)));

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (|req) next_state = ST_ARB;
            ST_ARB:      next_state = grant_valid ? ST_CLR0 : ST_IDLE;
            ST_CLR0:     next_state = ST_WR_PL;
            ST_WR_PL:    next_state = ST_WR_PH;
            ST_WR_PH:    next_state = ST_WR_CTRL;
            ST_WR_CTRL:  next_state = ST_WAIT_IRQ;
            ST_WAIT_IRQ: if (tmr_irq) next_state = ST_CLR1;
            ST_CLR1:     next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state into flops so each bus cycle lines up with its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            last           <= 3'(NUM_REQ - 1);
            active_id      <= '0;
            period         <= '0;
            busy           <= 1'b0;
            done           <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= '0;
            tmr_writedata  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state <= next_state;
            if (state == ST_ARB && grant_valid) begin
                active_id <= grant_idx;
                period    <= period_for(grant_delay);
            end
            if (state == ST_DONE) last <= active_id;

            busy <= (next_state != ST_IDLE);
            done <= (next_state == ST_DONE) ? (LSB_ONE << active_id) : '0;

            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= '0;
            tmr_writedata  <= '0;
            case (next_state)
                ST_CLR0, ST_CLR1: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_ADDR_STATUS;
                end
                ST_WR_PL: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_ADDR_PERIOD_L;
                    tmr_writedata  <= period[15:0];
                end
                ST_WR_PH: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_ADDR_PERIOD_H;
                    tmr_writedata  <= period[31:16];
                end
                ST_WR_CTRL: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= TMR_ADDR_CONTROL;
                    tmr_writedata  <= TMR_CTRL_START | TMR_CTRL_ITO;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_interval_timer_scheduler.sv
// Directed bench for interval_timer_scheduler with a behavioural one-shot timer model.
module tb_interval_timer_scheduler;

    typedef struct { int c; logic [2:0] a; logic [15:0] d; } wr_t;
    typedef struct { int c; logic [3:0] v; } dn_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_delay;
    logic [3:0]   done;
    logic         busy;
    logic [2:0]   active_id;
    logic [2:0]   tmr_address;
    logic         tmr_chipselect;
    logic         tmr_write_n;
    logic [15:0]  tmr_writedata;
    logic         tmr_irq;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  irq_rise = -1;
    logic irq_prev = 1'b0;
    wr_t wr_q[$];
    dn_t done_q[$];

    // Timer model state
    logic [15:0] tm_pl = '0, tm_ph = '0;
    logic [31:0] tm_count = '0;
    logic        tm_running = 1'b0, tm_timeout = 1'b0, tm_ito = 1'b0;
    logic        stale_req = 1'b0;

    interval_timer_scheduler #(.NUM_REQ(4), .DELAY_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .req_delay(req_delay), .done(done),
        .busy(busy), .active_id(active_id), .tmr_address(tmr_address),
        .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
        .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tmr_irq = tm_timeout & tm_ito;

    // One-shot timer: bus writes take precedence over counting in the same cycle.
    always @(posedge clk) begin
        if (tm_running) begin
            if (tm_count == 32'd0) begin
                tm_timeout <= 1'b1;
                tm_running <= 1'b0;
                tm_count   <= {tm_ph, tm_pl};
            end else begin
                tm_count <= tm_count - 32'd1;
            end
        end
        if (stale_req) begin
            tm_timeout <= 1'b1;
            tm_ito     <= 1'b1;
        end
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: tm_timeout <= 1'b0;
                3'd1: begin
                    tm_ito <= tmr_writedata[0];
                    if (tmr_writedata[2]) tm_running <= 1'b1;
                    if (tmr_writedata[3]) tm_running <= 1'b0;
                end
                3'd2: begin tm_pl <= tmr_writedata; tm_count <= {tm_ph, tmr_writedata}; tm_running <= 1'b0; end
                3'd3: begin tm_ph <= tmr_writedata; tm_count <= {tmr_writedata, tm_pl}; tm_running <= 1'b0; end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (tmr_chipselect && !tmr_write_n) wr_q.push_back('{c: cyc, a: tmr_address, d: tmr_writedata});
        if (done != 4'b0) done_q.push_back('{c: cyc, v: done});
        if (tmr_irq && !irq_prev) irq_rise = cyc;
        irq_prev = tmr_irq;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_done_n(input int n, input int budget, output bit ok);
        int k = 0;
        while (done_q.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        ok = (done_q.size() >= n);
    endtask

    task automatic set_delay(input int id, input logic [31:0] d);
        req_delay[32*id +: 32] = d;
    endtask

    task automatic get_wr(input int i, output int c, output logic [2:0] a, output logic [15:0] d);
        if (i < wr_q.size()) begin c = wr_q[i].c; a = wr_q[i].a; d = wr_q[i].d; end
        else begin c = -1; a = 3'd7; d = 16'hxxxx; end
    endtask

    task automatic get_done(input int i, output int c, output logic [3:0] v);
        if (i < done_q.size()) begin c = done_q[i].c; v = done_q[i].v; end
        else begin c = -1; v = 4'bxxxx; end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; req_delay = '0;
        wait_cycles(3);
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (active_id !== 3'd0) begin errors++; $display("FAIL reset_active_id: got %0d expected 0", active_id); end
        checks++;
        if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
            errors++;
            $display("FAIL reset_bus: got cs=%b wn=%b a=%0d d=%h expected cs=0 wn=1 a=0 d=0000",
                     tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
        end
        reset = 1'b0;
        wait_cycles(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int c0, gc; bit ok; logic [2:0] ga; logic [15:0] gd; logic [3:0] gv;
        logic [2:0] ea[5] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0};
        logic [15:0] ed[5] = '{16'h0000, 16'h0063, 16'h0000, 16'h0005, 16'h0000};
        int eo[5] = '{2, 3, 4, 5, 107};
        wr_q.delete(); done_q.delete(); irq_rise = -1;
        set_delay(1, 32'd100);
        c0 = cyc; req = 4'b0010;
        wait_done_n(1, 300, ok);
        checks++; if (active_id !== 3'd1) begin errors++; $display("FAIL single_active_id: got %0d expected 1", active_id); end
        req = 4'b0000;
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: done count %0d expected 1", done_q.size()); end
        for (int i = 0; i < 5; i++) begin
            get_wr(i, gc, ga, gd);
            checks++;
            if (ga !== ea[i] || gd !== ed[i] || gc !== c0 + eo[i]) begin
                errors++;
                $display("FAIL single_write%0d: got a=%0d d=%h cyc=%0d expected a=%0d d=%h cyc=%0d",
                         i, ga, gd, gc, ea[i], ed[i], c0 + eo[i]);
            end
        end
        checks++; if (irq_rise !== c0 + 106) begin errors++; $display("FAIL single_irq_time: got %0d expected %0d", irq_rise, c0 + 106); end
        get_done(0, gc, gv);
        checks++;
        if (gv !== 4'b0010 || gc !== c0 + 108) begin
            errors++; $display("FAIL single_done: got %b at %0d expected 0010 at %0d", gv, gc, c0 + 108);
        end
        wait_cycles(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_wide_delay();
        int c0, gc; bit ok; logic [2:0] ga; logic [15:0] gd; logic [3:0] gv;
        wr_q.delete(); done_q.delete();
        set_delay(0, 32'h0001_0000);
        c0 = cyc; req = 4'b0001;
        wait_done_n(1, 66000, ok);
        req = 4'b0000;
        get_wr(1, gc, ga, gd);
        checks++; if (ga !== 3'd2 || gd !== 16'hFFFF) begin errors++; $display("FAIL wide_period_l: got a=%0d d=%h expected a=2 d=ffff", ga, gd); end
        get_wr(2, gc, ga, gd);
        checks++; if (ga !== 3'd3 || gd !== 16'h0000) begin errors++; $display("FAIL wide_period_h: got a=%0d d=%h expected a=3 d=0000", ga, gd); end
        get_done(0, gc, gv);
        checks++;
        if (!ok || gv !== 4'b0001 || gc !== c0 + 65544) begin
            errors++; $display("FAIL wide_done: got %b at %0d expected 0001 at %0d", gv, gc, c0 + 65544);
        end
        wait_cycles(2);
    endtask

    task automatic test_clamp();
        int c0, gc; bit ok; logic [2:0] ga; logic [15:0] gd; logic [3:0] gv;
        wr_q.delete(); done_q.delete();
        set_delay(2, 32'd1);
        c0 = cyc; req = 4'b0100;
        wait_done_n(1, 100, ok);
        req = 4'b0000;
        get_wr(1, gc, ga, gd);
        checks++; if (ga !== 3'd2 || gd !== 16'h0001) begin errors++; $display("FAIL clamp_period_l: got a=%0d d=%h expected a=2 d=0001", ga, gd); end
        get_wr(2, gc, ga, gd);
        checks++; if (ga !== 3'd3 || gd !== 16'h0000) begin errors++; $display("FAIL clamp_period_h: got a=%0d d=%h expected a=3 d=0000", ga, gd); end
        get_done(0, gc, gv);
        checks++;
        if (!ok || gv !== 4'b0100 || gc !== c0 + 10) begin
            errors++; $display("FAIL clamp_done: got %b at %0d expected 0100 at %0d", gv, gc, c0 + 10);
        end
        wait_cycles(2);
    endtask

    task automatic test_stale_irq();
        int c0, gc; bit ok; logic [2:0] ga; logic [15:0] gd; logic [3:0] gv;
        stale_req = 1'b1; wait_cycles(1); stale_req = 1'b0;
        wait_cycles(2);
        wr_q.delete(); done_q.delete();
        set_delay(3, 32'd20);
        c0 = cyc; req = 4'b1000;
        wait_cycles(6);
        checks++; if (tmr_irq !== 1'b0) begin errors++; $display("FAIL stale_irq_low: got %b expected 0 at WAIT_IRQ entry", tmr_irq); end
        get_wr(0, gc, ga, gd);
        checks++;
        if (ga !== 3'd0 || gd !== 16'h0000 || gc !== c0 + 2) begin
            errors++; $display("FAIL stale_clr0: got a=%0d d=%h cyc=%0d expected a=0 d=0000 cyc=%0d", ga, gd, gc, c0 + 2);
        end
        wait_done_n(1, 100, ok);
        req = 4'b0000;
        get_done(0, gc, gv);
        checks++;
        if (!ok || gv !== 4'b1000 || gc !== c0 + 28) begin
            errors++; $display("FAIL stale_done: got %b at %0d expected 1000 at %0d", gv, gc, c0 + 28);
        end
        wait_cycles(2);
    endtask

    task automatic test_back_to_back();
        int c0, gc, pc; bit ok; logic [3:0] gv;
        logic [3:0] ev[4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        int eg[4] = '{11, 13, 15, 12};
        reset = 1'b1; wait_cycles(2); reset = 1'b0;
        set_delay(0, 32'd3); set_delay(1, 32'd4); set_delay(3, 32'd6);
        wr_q.delete(); done_q.delete();
        c0 = cyc; req = 4'b1011;
        wait_done_n(4, 200, ok);
        req = 4'b0000;
        checks++; if (!ok) begin errors++; $display("FAIL contention_timeout: done count %0d expected 4", done_q.size()); end
        pc = c0;
        for (int i = 0; i < 4; i++) begin
            get_done(i, gc, gv);
            checks++;
            if (gv !== ev[i] || gc - pc !== eg[i]) begin
                errors++; $display("FAIL contention_service%0d: got %b gap %0d expected %b gap %0d", i, gv, gc - pc, ev[i], eg[i]);
            end
            pc = gc;
        end
        wait_cycles(2);
    endtask

    task automatic test_request_drop();
        int c0, gc; bit ok; logic [3:0] gv;
        wr_q.delete(); done_q.delete();
        set_delay(2, 32'd30);
        c0 = cyc; req = 4'b0100;
        wait_cycles(3);
        set_delay(2, 32'd500);
        wait_cycles(7);
        req = 4'b0000;
        wait_done_n(1, 100, ok);
        get_done(0, gc, gv);
        checks++;
        if (!ok || gv !== 4'b0100 || gc !== c0 + 38) begin
            errors++; $display("FAIL drop_done: got %b at %0d expected 0100 at %0d", gv, gc, c0 + 38);
        end
        wait_cycles(20);
        checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL drop_single_pulse: got %0d pulses expected 1", done_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_in_wait();
        int gc; bit ok; logic [3:0] gv;
        done_q.delete();
        set_delay(1, 32'd5);
        req = 4'b0010;
        wait_done_n(1, 100, ok);
        req = 4'b0000;
        checks++; if (!ok) begin errors++; $display("FAIL rst_pre_service: done count %0d expected 1", done_q.size()); end
        wait_cycles(2);
        set_delay(3, 32'd1000);
        req = 4'b1000;
        wait_cycles(15);
        done_q.delete();
        reset = 1'b1; req = 4'b0000;
        wait_cycles(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++;
        if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
            errors++;
            $display("FAIL rst_bus: got cs=%b wn=%b a=%0d d=%h expected cs=0 wn=1 a=0 d=0000",
                     tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
        end
        reset = 1'b0;
        wait_cycles(3);
        checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", done_q.size()); end
        set_delay(1, 32'd7); set_delay(2, 32'd8);
        req = 4'b0110;
        wait_done_n(1, 100, ok);
        req = 4'b0000;
        get_done(0, gc, gv);
        checks++; if (!ok || gv !== 4'b0010) begin errors++; $display("FAIL rst_priority: got %b expected 0010", gv); end
        wait_cycles(3);
    endtask

    initial begin
        test_reset();
        test_single();
        test_wide_delay();
        test_clamp();
        test_stale_irq();
        test_back_to_back();
        test_request_drop();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interval_timer_scheduler.md
# interval_timer_scheduler

Shares one Avalon-MM interval timer (16-bit register map, 32-bit down-counter, single `irq`) among `NUM_REQ` requesters that each need a one-shot delay. It arbitrates round-robin, programs the period registers, starts the timer in one-shot mode with interrupt enabled, waits for `irq`, clears the timeout status and pulses `done` to the winner. It sits between client logic (sequencers, debouncers, motor step generators) and the timer's `s1` slave, and is the timer's only Avalon master.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DELAY_W`, 32: requested-delay width in clock cycles. Fixed at 32 to match the timer counter.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: level request per requester. Held high until the matching `done`.
- `req_delay` in NUM_REQ*32: per-requester delay in cycles; slice i = `[32*i+31:32*i]`.
- `done` out NUM_REQ: one-cycle pulse to the served requester at completion.
- `busy` out 1: high in every state except IDLE.
- `active_id` out 3: index of the requester being served. Valid while `busy`.
- `tmr_address` out 3: timer word address.
- `tmr_chipselect` out 1: timer chip select.
- `tmr_write_n` out 1: timer write strobe, active-low.
- `tmr_writedata` out 16: timer write data.
- `tmr_irq` in 1: timer interrupt (timeout status AND interrupt enable).

## Operation
- Timer map: 0 status (any write clears timeout); 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP); 2 period_l; 3 period_h.
  - A period write forces a reload and stops the counter.
  - The timer has no waitrequest, so every write completes in one cycle.
- FSM states: IDLE → ARB → CLR0 → WR_PL → WR_PH → WR_CTRL → WAIT_IRQ → CLR1 → DONE → IDLE.
  - IDLE: if `req` ≠ 0, go to ARB.
  - ARB: round-robin grant, searching from `last+1` modulo NUM_REQ. Latch `active_id` and the clamped delay D.
  - CLR0: write 0 to addr 0 to flush any stale timeout.
  - WR_PL: write `(D-1)[15:0]` to addr 2.
  - WR_PH: write `(D-1)[31:16]` to addr 3.
  - WR_CTRL: write 0x0005 (START|ITO, CONT=0) to addr 1.
  - WAIT_IRQ: stay until `tmr_irq` = 1.
  - CLR1: write 0 to addr 0.
  - DONE: `done[active_id]` = 1; `last` ← `active_id`; go to IDLE.
- Delay clamp: a requested delay below 2 is replaced by 2, so the period written is never 0. A zero period would produce no counter-is-zero edge and the FSM would hang.
- The timer expires D cycles after the START write takes effect (counts D-1 down to 0).
- The delay is sampled only in ARB. Later changes to `req_delay` have no effect on the current service.
- If `req[active_id]` drops mid-service, the service still completes and `done` is still pulsed. The requester must ignore it.
- Write-bus idle values: `tmr_chipselect`=0, `tmr_write_n`=1, `tmr_address`=0, `tmr_writedata`=0.
- Reset mid-operation: the FSM returns to IDLE and `last` resets to NUM_REQ-1, so requester 0 has first priority. The timer is not reset by this block. The CLR0 and period writes of the next service resynchronise it.

## Timing
- All outputs are registered (Moore outputs decoded into flops). Reset values: `done`=0, `busy`=0, `active_id`=0, bus at idle values.
- Each write state asserts `tmr_chipselect`=1 and `tmr_write_n`=0 for exactly one cycle. There are four consecutive write cycles: CLR0, WR_PL, WR_PH, WR_CTRL.
- Latency from the `req` rising edge seen in IDLE to the WR_CTRL bus cycle is 5 clocks.
- Latency from the `tmr_irq` rise to the `done` pulse is 2 clocks (CLR1, DONE).
- `tmr_irq` is checked only in WAIT_IRQ. After the CLR1 write, `irq` falls on the following edge, before the next WAIT_IRQ.
- Back-to-back service: IDLE is always visited for 1 cycle between services. The minimum service period is D + 9 cycles.
- Simultaneous requests: exactly one grant per ARB. All pending requesters are served before any requester repeats.

## Structure
- Package `interval_timer_pkg` holds:
  - register address constants `TMR_ADDR_STATUS`/`CONTROL`/`PERIOD_L`/`PERIOD_H`;
  - control bit constants `TMR_CTRL_ITO`/`CONT`/`START`/`STOP`;
  - the FSM state enum;
  - `TMR_MIN_DELAY` = 2.
- Sub-module `rr_arbiter`: parameterised on NUM_REQ. Inputs are the request vector and the last-grant pointer; output is the one-hot/index grant. It is combinational and registered by the parent in ARB.

## Test plan
- Single request: `req[1]`=1, delay 100. Expect bus writes: addr0 0; addr2 0x0063; addr3 0x0000; addr1 0x0005. Timer model raises `irq` 100 cycles after START; `done[1]` pulses 2 cycles later.
- 32-bit delay: delay 0x0001_0000. Expect period_l 0xFFFF and period_h 0x0000. A delay of 1 clamps to 2: expect period_l 0x0001 and period_h 0x0000.
- Contention: `req`=4'b1011 held after reset. Expect service order 0, 1, 3, 0 and exactly one `done` bit per service.
- Stale irq: `tmr_irq` held high before the request. Expect the CLR0 write, `irq` low by WAIT_IRQ, and no early `done`.
- Reset in WAIT_IRQ: assert `reset` for 1 cycle. Expect `busy`=0, bus at idle values and no `done` pulse. The re-asserted request is served afresh starting from requester 0 priority.
- Request drop: `req[2]` deasserted during WAIT_IRQ. Expect the service to finish and `done[2]` to pulse once.
